hwpe_buffer_reader: RTL and testbench

Sequential read initiator for the HWPE word buffer. On a start pulse it walks a configured address window of the buffer, issuing one read request per cycle, and presents each word on a valid/ready output stream. It sits between the buffer's memory port and the engine datapath, and applies backpressure by stalling requests. Address generation wraps modulo `NumWords`.

---
 rtl/hwpe_buffer_reader_if.sv | 34 +++
 rtl/hwpe_buffer_reader.sv | 94 +++++++++
 tb/tb_hwpe_buffer_reader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_buffer_reader_if.sv
// Bundle of the reader's control, buffer-port and output-stream signals.
// The master modport is the reader's view. The slave modport is the view of
// the surrounding engine and buffer.
interface hwpe_buffer_reader_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned LenWidth  = 8
);
    logic                 start_i;
    logic [AddrWidth-1:0] base_addr_i;
    logic [LenWidth-1:0]  len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_wdata_o;
    logic [DataWidth-1:0] mem_rdata_i;
    logic [DataWidth-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        input  start_i, base_addr_i, len_i, mem_rdata_i, ready_i,
        output busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               data_o, valid_o
    );

    modport slave (
        output start_i, base_addr_i, len_i, mem_rdata_i, ready_i,
        input  busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               data_o, valid_o
    );
endinterface

// File: rtl/hwpe_buffer_reader.sv
// Sequential read initiator for the HWPE word buffer. It walks an address
// window that wraps at NumWords and streams each word out on valid/ready.
// A full output register stalls new requests.
module hwpe_buffer_reader #(
    parameter int unsigned NumWords  = 128,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = $clog2(NumWords),
    parameter int unsigned LenWidth  = AddrWidth + 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    hwpe_buffer_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    state_t               state;
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  rem;
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 zero_done;
    logic                 req;
    logic                 hs;

    // The request depends combinationally on ready, so a draining output
    // register can be refilled in the same cycle without a bubble.
    always_comb begin
        hs  = valid && bus.ready_i;
        req = (state == RUN) && (rem != '0) && (!valid || bus.ready_i);
    end

    // FSM, address and length counters, and the output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            data      <= '0;
            valid     <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (req) begin
                data  <= bus.mem_rdata_i;
                valid <= 1'b1;
            end else if (hs) begin
                valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        addr <= bus.base_addr_i;
                        rem  <= bus.len_i;
                        if (bus.len_i != '0) begin
                            state <= RUN;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (req) begin
                        rem  <= rem - LenWidth'(1);
                        addr <= (addr == LastAddr) ? '0 : addr + AddrWidth'(1);
                        if (rem == LenWidth'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // done_o fires in the final handshake cycle itself. For a zero-length
    // start it fires one cycle after the start.
    always_comb begin
        bus.busy_o      = (state != IDLE);
        bus.done_o      = zero_done || ((state == DRAIN) && hs);
        bus.mem_req_o   = req;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = addr;
        bus.mem_wdata_o = '0;
        bus.data_o      = data;
        bus.valid_o     = valid;
    end
endmodule

// File: tb/tb_hwpe_buffer_reader.sv
// Self-checking bench for hwpe_buffer_reader: a buffer model, a request/data
// scoreboard, table-driven transfers and hand-written corner sequences.
module tb_hwpe_buffer_reader;
    localparam int NW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hwpe_buffer_reader_if #(.DataWidth(32), .AddrWidth(7), .LenWidth(8)) bus ();

    hwpe_buffer_reader #(.NumWords(NW), .DataWidth(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] mem [NW];
    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    logic [6:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic        stall_pend = 1'b0;
    logic [31:0] stall_data;
    logic        first_pend = 1'b0;
    logic [31:0] first_data;
    logic [31:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sample away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_pend) begin
                    chk("stall_valid", bus.valid_o, 1);
                    chk("stall_data", bus.data_o, stall_data);
                    stall_pend = 1'b0;
                end
                if (bus.mem_req_o) begin
                    req_cnt++;
                    chk("req_busy", bus.busy_o, 1);
                    chk("req_we", bus.mem_we_o, 0);
                    chk("req_wdata", bus.mem_wdata_o, 0);
                    chk("req_when_stalled", bus.valid_o && !bus.ready_i, 0);
                    if (exp_addr.size() == 0) chk("req_unexpected", 1, 0);
                    else chk("req_addr", bus.mem_addr_o, exp_addr.pop_front());
                end
                if (bus.valid_o && bus.ready_i) begin
                    beat_cnt++;
                    last_data = bus.data_o;
                    if (first_pend) begin
                        first_data = bus.data_o;
                        first_pend = 1'b0;
                    end
                    if (exp_data.size() == 0) chk("beat_unexpected", 1, 0);
                    else chk("beat_data", bus.data_o, exp_data.pop_front());
                end
                if (bus.valid_o && !bus.ready_i) begin
                    stall_data = bus.data_o;
                    stall_pend = 1'b1;
                end
                if (bus.done_o) done_cnt++;
            end
        end
    end

    task automatic expect_window(input int base, input int len);
        for (int k = 0; k < len; k++) begin
            exp_addr.push_back(7'((base + k) % NW));
            exp_data.push_back(32'h100 + 32'((base + k) % NW));
        end
        first_pend = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"}, bus.busy_o, 0);
        chk({name, "_done"}, bus.done_o, 0);
        chk({name, "_req"}, bus.mem_req_o, 0);
        chk({name, "_addr"}, bus.mem_addr_o, 0);
        chk({name, "_valid"}, bus.valid_o, 0);
        chk({name, "_data"}, bus.data_o, 0);
    endtask

    // One full transfer; spur_at >= 0 injects a second start in that cycle.
    task automatic run_xfer(input string name, input int base, input int len,
                            input logic [7:0] pat, input int spur_at,
                            input logic [31:0] exp_first, input logic [31:0] exp_last);
        int d0 = done_cnt;
        int b0 = beat_cnt;
        logic seen = 1'b0;
        int budget = len * 8 + 20;
        expect_window(base, len);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.base_addr_i = 7'(base);
        bus.len_i = 8'(len);
        bus.ready_i = pat[0];
        for (int c = 1; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            bus.start_i = (c == spur_at);
            if (c == spur_at) begin
                bus.base_addr_i = 7'd50;
                bus.len_i = 8'd7;
            end
            bus.ready_i = pat[c % 8];
            if (done_cnt != d0) seen = 1'b1;
        end
        chk({name, "_timeout"}, seen, 1);
        bus.start_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_count"}, done_cnt - d0, 1);
        chk({name, "_beats"}, beat_cnt - b0, len);
        chk({name, "_leftover"}, exp_data.size() + exp_addr.size(), 0);
        chk({name, "_first"}, first_data, exp_first);
        chk({name, "_last"}, last_data, exp_last);
        chk({name, "_idle"}, bus.busy_o, 0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    typedef struct {
        string       name;
        int          base;
        int          len;
        logic [7:0]  pat;
        int          spur;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    typedef struct {
        logic        req;
        logic [6:0]  addr;
        logic        valid;
        logic [31:0] data;
        logic        done;
        logic        busy;
    } cyc_t;

    initial begin
        vec_t vecs[5];
        cyc_t tim[5];
        int d0;
        int r0;
        int b0;

        vecs[0] = '{"basic",    4,   3,   8'hFF,        -1, 32'h104, 32'h106};
        vecs[1] = '{"wrap",     126, 4,   8'hFF,        -1, 32'h17E, 32'h101};
        vecs[2] = '{"bp",       20,  4,   8'b1001_1001, -1, 32'h114, 32'h117};
        vecs[3] = '{"spurious", 10,  5,   8'hFF,        2,  32'h10A, 32'h10E};
        vecs[4] = '{"long",     120, 130, 8'b1011_0110, -1, 32'h178, 32'h179};

        tim[0] = '{1'b1, 7'd4, 1'b0, 32'h000, 1'b0, 1'b1};
        tim[1] = '{1'b1, 7'd5, 1'b1, 32'h104, 1'b0, 1'b1};
        tim[2] = '{1'b1, 7'd6, 1'b1, 32'h105, 1'b0, 1'b1};
        tim[3] = '{1'b0, 7'd7, 1'b1, 32'h106, 1'b1, 1'b1};
        tim[4] = '{1'b0, 7'd7, 1'b0, 32'h106, 1'b0, 1'b0};

        for (int i = 0; i < NW; i++) mem[i] = 32'h100 + 32'(i);
        bus.start_i = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i = '0;
        bus.ready_i = 1'b0;

        #22;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Exact cycle timing of a 3-word transfer.
        expect_window(4, 3);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.base_addr_i = 7'd4;
        bus.len_i = 8'd3;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("tim%0d_req", c + 1), bus.mem_req_o, tim[c].req);
            if (tim[c].req) chk($sformatf("tim%0d_addr", c + 1), bus.mem_addr_o, tim[c].addr);
            chk($sformatf("tim%0d_valid", c + 1), bus.valid_o, tim[c].valid);
            if (tim[c].valid) chk($sformatf("tim%0d_data", c + 1), bus.data_o, tim[c].data);
            chk($sformatf("tim%0d_done", c + 1), bus.done_o, tim[c].done);
            chk($sformatf("tim%0d_busy", c + 1), bus.busy_o, tim[c].busy);
        end
        exp_addr.delete();
        exp_data.delete();

        // Table-driven transfers.
        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].pat,
                     vecs[v].spur, vecs[v].first, vecs[v].last);
        end

        // Zero length: done next cycle, no request, no data.
        d0 = done_cnt;
        r0 = req_cnt;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.base_addr_i = 7'd9;
        bus.len_i = 8'd0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("zero_done", bus.done_o, 1);
        chk("zero_busy", bus.busy_o, 0);
        chk("zero_valid", bus.valid_o, 0);
        @(negedge clk);
        chk("zero_done_once", bus.done_o, 0);
        repeat (3) @(negedge clk);
        chk("zero_no_req", req_cnt - r0, 0);
        chk("zero_done_count", done_cnt - d0, 1);
        chk("zero_valid_end", bus.valid_o, 0);

        // Reset mid-transfer after two delivered words.
        d0 = done_cnt;
        b0 = beat_cnt;
        expect_window(30, 6);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.base_addr_i = 7'd30;
        bus.len_i = 8'd6;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 0; c < 20 && beat_cnt - b0 < 2; c++) @(negedge clk);
        chk("rst_two_beats", beat_cnt - b0, 2);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_async");
        exp_addr.delete();
        exp_data.delete();
        stall_pend = 1'b0;
        first_pend = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle", bus.busy_o, 0);
        run_xfer("after_rst", 0, 2, 8'hFF, -1, 32'h100, 32'h101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
